// File: rtl/slc3_sram_ctrl.sv
// SLC-3 on-chip SRAM with ROM image preload and CPU read/write port.
// Optional write protection of low addresses: define SLC3_SRAM_WRPROT_EN.
module slc3_sram_ctrl #(
  parameter int          ADDR_W     = 10,
  parameter int          INIT_WORDS = 256,
  parameter logic [15:0] PROT_LIMIT = 16'h0040
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [15:0]       ADDR,
  input  logic              OE,
  input  logic              WE,
  input  logic [15:0]       Data_to_SRAM,
  output logic [15:0]       Data_from_SRAM,
  output logic [ADDR_W-1:0] Rom_Addr,
  input  logic [15:0]       Rom_Data,
  input  logic              Prot_Enable,
  output logic              Init_Busy,
  output logic              Init_Done,
  output logic              Prot_Violation
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;
  localparam logic [CW-1:0] LAST = CW'(INIT_WORDS - 1);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic              init_vld_q;
  logic              we_q;
  logic              prot_q;
  logic [15:0]       dout_q;
  logic [15:0]       mem [DEPTH];

  logic [ADDR_W-1:0] a;
  logic              run;
  logic              wr_req;
  logic              wr_fire;
  logic              rd_fire;
  logic              prot_hit;
  logic              unused_bits;

  assign a   = ADDR[ADDR_W-1:0];
  assign run = (state == S_RUN);

  // Only the first cycle of a WE low pulse is a write.
  assign wr_req  = run && !WE && we_q;
  assign rd_fire = run && !OE && WE;

`ifdef SLC3_SRAM_WRPROT_EN
  assign prot_hit = Prot_Enable && (32'(a) < 32'(PROT_LIMIT));
`else
  assign prot_hit = 1'b0;
`endif

  assign wr_fire     = wr_req && !prot_hit;
  assign unused_bits = ^{Prot_Enable, ADDR};

  assign Rom_Addr       = (state == S_INIT) ? cnt[ADDR_W-1:0] : '0;
  assign Init_Busy      = !run;
  assign Init_Done      = run;
  assign Data_from_SRAM = dout_q;
  assign Prot_Violation = prot_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_INIT;
      cnt        <= '0;
      wr_ptr_q   <= '0;
      init_vld_q <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (INIT_WORDS == 0) begin
            state      <= S_RUN;
            init_vld_q <= 1'b0;
          end else begin
            wr_ptr_q   <= cnt[ADDR_W-1:0];
            init_vld_q <= 1'b1;
            if (cnt == LAST) begin
              state <= S_DRAIN;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          init_vld_q <= 1'b0;
          state      <= S_RUN;
        end
        S_RUN: begin
          init_vld_q <= 1'b0;
        end
        default: begin
          state      <= S_INIT;
          init_vld_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dout_q <= '0;
      we_q   <= 1'b1;
      prot_q <= 1'b0;
    end else begin
      we_q <= WE;
      if (rd_fire) dout_q <= mem[a];
      if (wr_req && prot_hit) prot_q <= 1'b1;
    end
  end

  // ROM data lags its address by one cycle, hence the delayed pointer.
  always_ff @(posedge Clk) begin
    if (init_vld_q) mem[wr_ptr_q] <= Rom_Data;
    else if (wr_fire) mem[a] <= Data_to_SRAM;
  end

endmodule
